axi_wr_arbiter: RTL and testbench
=================================

Name: axi_wr_arbiter

Overview:
- Two-master to one-slave arbiter for the AXI write path (AW, W, B) on the team's AXI3-style bus: 4-bit len, 2-bit lock, explicit wid.
- Sits between two verification masters (or DMA engines) and a single slave model or DUT port.
- Serialises whole write bursts with round-robin fairness.
- Tags the downstream ID with the master index and routes write responses back by that tag.

Parameters:
- ID_W, 4, upstream transaction ID width; downstream IDs are ID_W+1 wide.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- aclk  in  1  clock; all state changes on posedge.
- arst  in  1  reset, synchronous, active-high.
- m_awvalid  in  2  per-master AW valid.
- m_awready  out  2  per-master AW ready.
- m_aw  in  2 x AW_T  per-master AW payload {id,addr,len,size,burst,lock,cache,prot,qos,region}.
- m_wvalid  in  2  per-master W valid.
- m_wready  out  2  per-master W ready.
- m_w  in  2 x W_T  per-master W payload {id,data,strb,last}.
- m_bvalid  out  2  per-master B valid.
- m_bready  in  2  per-master B ready.
- m_b  out  B_T  B payload {id[ID_W-1:0],resp}, shared by both masters, qualified by m_bvalid.
- s_awvalid  out  1  slave AW valid.
- s_awready  in  1  slave AW ready.
- s_aw  out  AWX_T  AW payload with id = {grant, m_id}.
- s_wvalid  out  1  slave W valid.
- s_wready  in  1  slave W ready.
- s_w  out  WX_T  W payload with wid = {grant, m_wid}.
- s_bvalid  in  1  slave B valid.
- s_bready  out  1  slave B ready.
- s_b  in  BX_T  slave B payload, id ID_W+1 wide.
- grant  out  1  index of the master currently owning AW/W.
- busy  out  1  high in ADDR or DATA state.
- len_err  out  1  one-cycle pulse on a beat-count/wlast mismatch.

Behaviour:
- Reset (arst sampled high at posedge):
  - State goes to IDLE; last_grant=1, so master 0 wins first; beat counter=0; AW register cleared.
  - While arst is high, every valid/ready output is forced to 0 combinationally; grant=0, busy=0, len_err=0.
  - Reset mid-burst abandons the burst; no completion is emitted.
- FSM IDLE:
  - The selected master sees m_awready=1 combinationally; all others see 0.
  - Selection: if both m_awvalid are high, pick !last_grant; if one is high, pick it.
  - On handshake, register {sel, m_aw[sel]} into the AW register, set grant=sel, clear the beat counter, go to ADDR.
- FSM ADDR:
  - s_awvalid=1 from the register; payload stays stable until s_awready.
  - On s_awvalid&&s_awready, go to DATA.
  - Latency: upstream AW accepted at cycle N drives s_awvalid at N+1 at the earliest.
- FSM DATA:
  - Forwarding: s_wvalid=m_wvalid[grant]; s_w={grant, m_w[grant]}; m_wready[grant]=s_wready; the other m_wready=0.
  - Each s_w handshake increments the 4-bit beat counter.
  - On a handshake with wlast=1: go to IDLE and set last_grant=grant.
  - len_err pulses on the cycle after a handshake where (counter==len && !wlast) or (wlast && counter!=len). The pulse fires once per such beat.
  - The burst always terminates on wlast, never on count; the counter wraps at 16.
  - W beats presented before their AW are stalled (m_wready=0); wid is not checked.
- Arbitration rules:
  - A master is never granted a second burst while the other has a pending request.
  - IDLE lasts at least one cycle between bursts.
- B channel (combinational, independent of the FSM; runs concurrently with AW/W):
  - k = s_b.id[ID_W].
  - m_bvalid[k] = s_bvalid; the other m_bvalid=0.
  - m_b = {s_b.id[ID_W-1:0], s_b.resp}.
  - s_bready = m_bready[k].
- busy = (state != IDLE).

Decomposition:
- Package axi_arb_pkg holds:
  - Typedefs aw_t, w_t, b_t (upstream) and awx_t, wx_t, bx_t (downstream, ID_W+1), derived from ID_W/ADDR_W/DATA_W localparams.
  - State enum {IDLE, ADDR, DATA}.
- One sub-module: axi_rr_arb2, a 2-way round-robin picker holding last_grant. It takes a req[1:0] input and an update strobe, and outputs sel.

Test Plan:
- Reset, then only master 0 drives AW id=3 addr=0x100 len=3 with 4 W beats, slave always ready:
  - s_awvalid rises 1 cycle after the m_awready handshake with s_aw.id=0x03.
  - 4 s_w beats with wid=0x03; len_err never pulses; busy drops after the last beat.
- Both masters assert AW in the same cycle after reset:
  - Master 0 is granted first.
  - Master 1 is granted in the first IDLE cycle after master 0's wlast, with s_aw.id={1,id1}.
- Slave holds s_awready=0 for 5 cycles and toggles s_wready 1/0:
  - s_aw stays stable and s_awvalid stays held.
  - m_wready[grant] mirrors s_wready; no beats are lost or duplicated.
- Master 1 sends len=3 but asserts wlast on beat 2 (counter=1):
  - len_err pulses exactly once.
  - FSM returns to IDLE; no further beats are forwarded.
- Slave returns B id=0x15 resp=2 with m_bready[1]=0 for 3 cycles:
  - m_bvalid=2'b10 and m_b.id=0x5; s_bready stays low until m_bready[1]=1.
  - Also run with a W burst in flight: B routing is unaffected.
- arst asserted during DATA after beat 1:
  - All valid/ready outputs are 0 that cycle.
  - After release, the FSM is in IDLE and master 0 has priority on a simultaneous request.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types for the two-master AXI3-style write arbiter.
// Bus widths are fixed here; downstream IDs carry one extra bit for the master tag.
package axi_arb_pkg;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [1:0]        lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
    } aw_t;

    typedef struct packed {
        logic [ID_W:0]     id;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [1:0]        lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
    } awx_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
    } w_t;

    typedef struct packed {
        logic [ID_W:0]     id;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
    } wx_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_t;

    typedef struct packed {
        logic [ID_W:0] id;
        logic [1:0]    resp;
    } bx_t;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    function automatic awx_t tag_aw(input logic m, input aw_t a);
        awx_t x;
        x.id     = {m, a.id};
        x.addr   = a.addr;
        x.len    = a.len;
        x.size   = a.size;
        x.burst  = a.burst;
        x.lock   = a.lock;
        x.cache  = a.cache;
        x.prot   = a.prot;
        x.qos    = a.qos;
        x.region = a.region;
        return x;
    endfunction

    function automatic wx_t tag_w(input logic m, input w_t w);
        wx_t x;
        x.id   = {m, w.id};
        x.data = w.data;
        x.strb = w.strb;
        x.last = w.last;
        return x;
    endfunction

endpackage

// File: rtl/axi_rr_arb2.sv
// Two-way round-robin picker; the master not granted last time wins a tie.
module axi_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic       sel
);

    logic last_grant;

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'b1;
        else if (update)
            last_grant <= sel;
    end

    always_comb begin
        sel = (&req) ? ~last_grant : req[1];
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Two-master to one-slave AXI3-style write arbiter: serialises whole bursts,
// tags downstream IDs with the master index and routes B back by that tag.
module axi_wr_arbiter
    import axi_arb_pkg::*;
(
    input  logic       aclk,
    input  logic       arst,
    input  logic [1:0] m_awvalid,
    output logic [1:0] m_awready,
    input  aw_t  [1:0] m_aw,
    input  logic [1:0] m_wvalid,
    output logic [1:0] m_wready,
    input  w_t   [1:0] m_w,
    output logic [1:0] m_bvalid,
    input  logic [1:0] m_bready,
    output b_t         m_b,
    output logic       s_awvalid,
    input  logic       s_awready,
    output awx_t       s_aw,
    output logic       s_wvalid,
    input  logic       s_wready,
    output wx_t        s_w,
    input  logic       s_bvalid,
    output logic       s_bready,
    input  bx_t        s_b,
    output logic       grant,
    output logic       busy,
    output logic       len_err
);

    state_t     state;
    awx_t       aw_q;
    logic       grant_q;
    logic [3:0] cnt;
    logic       len_err_q;
    logic       sel;
    logic       aw_hs;
    logic       w_hs;
    logic       k;

    assign aw_hs = !arst && (state == IDLE) && (|m_awvalid);
    assign w_hs  = !arst && (state == DATA) && m_wvalid[grant_q] && s_wready;

    // Fairness state advances at AW acceptance; equivalent to updating at wlast
    // since the next grant decision is only taken back in IDLE.
    axi_rr_arb2 u_rr (
        .clk    (aclk),
        .rst    (arst),
        .req    (m_awvalid),
        .update (aw_hs),
        .sel    (sel)
    );

    always_ff @(posedge aclk) begin
        if (arst) begin
            state     <= IDLE;
            aw_q      <= '0;
            grant_q   <= 1'b0;
            cnt       <= '0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        aw_q    <= tag_aw(sel, m_aw[sel]);
                        grant_q <= sel;
                        cnt     <= '0;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_awready)
                        state <= DATA;
                end
                DATA: begin
                    if (w_hs) begin
                        cnt       <= cnt + 4'd1;
                        len_err_q <= (cnt == aw_q.len) != m_w[grant_q].last;
                        if (m_w[grant_q].last)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        m_awready = '0;
        m_wready  = '0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        if (!arst) begin
            case (state)
                IDLE: if (|m_awvalid) m_awready[sel] = 1'b1;
                ADDR: s_awvalid = 1'b1;
                DATA: begin
                    s_wvalid          = m_wvalid[grant_q];
                    m_wready[grant_q] = s_wready;
                end
                default: ;
            endcase
        end
    end

    assign s_aw    = aw_q;
    assign s_w     = tag_w(grant_q, m_w[grant_q]);
    assign grant   = !arst && grant_q;
    assign busy    = !arst && (state != IDLE);
    assign len_err = !arst && len_err_q;

    // Response path is independent of the burst FSM.
    assign k = s_b.id[ID_W];

    always_comb begin
        m_bvalid = '0;
        if (!arst)
            m_bvalid[k] = s_bvalid;
        s_bready  = !arst && m_bready[k];
        m_b.id    = s_b.id[ID_W-1:0];
        m_b.resp  = s_b.resp;
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Self-checking bench for axi_wr_arbiter: per-master AW/W scoreboards, a B routing
// vector table and hand-written reset/backpressure/length-error sequences.
module tb_axi_wr_arbiter;
    import axi_arb_pkg::*;

    logic       aclk = 1'b0;
    logic       arst;
    logic [1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    aw_t  [1:0] m_aw;
    w_t   [1:0] m_w;
    b_t         m_b;
    logic       s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    awx_t       s_aw;
    wx_t        s_w;
    bx_t        s_b;
    logic       grant, busy, len_err;

    axi_wr_arbiter dut (
        .aclk(aclk), .arst(arst),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_aw(m_aw),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_w(m_w),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_b(m_b),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw(s_aw),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_w(s_w),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_b(s_b),
        .grant(grant), .busy(busy), .len_err(len_err)
    );

    always #5 aclk = ~aclk;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   len_err_cnt = 0;
    int   acc1_cyc = -1;
    int   wlast0_cyc = -1;
    awx_t exp_aw0[$], exp_aw1[$];
    wx_t  exp_w0[$], exp_w1[$];
    logic aw_order[$];
    logic done;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got timeout/none expected event", nm);
    endtask

    // Scoreboard side: pop expected slave-side traffic by master tag.
    always @(negedge aclk) begin
        awx_t ea;
        wx_t  ew;
        if (!arst) begin
            if (s_awvalid && s_awready) begin
                aw_order.push_back(s_aw.id[ID_W]);
                if (s_aw.id[ID_W] ? exp_aw1.size() == 0 : exp_aw0.size() == 0)
                    fail_now("aw_unexpected");
                else begin
                    ea = s_aw.id[ID_W] ? exp_aw1.pop_front() : exp_aw0.pop_front();
                    chk("s_aw", 128'(s_aw), 128'(ea));
                end
            end
            if (s_wvalid && s_wready) begin
                if (s_w.last && !s_w.id[ID_W]) wlast0_cyc = cyc;
                if (s_w.id[ID_W] ? exp_w1.size() == 0 : exp_w0.size() == 0)
                    fail_now("w_unexpected");
                else begin
                    ew = s_w.id[ID_W] ? exp_w1.pop_front() : exp_w0.pop_front();
                    chk("s_w", 128'(s_w), 128'(ew));
                end
            end
            if (m_awvalid[1] && m_awready[1]) acc1_cyc = cyc;
            if (len_err) len_err_cnt++;
        end
    end

    task automatic send_aw(input logic m, input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len);
        aw_t  a;
        awx_t e;
        int   t;
        a = '0; a.id = id; a.addr = addr; a.len = len; a.size = 3'd2; a.burst = 2'b01;
        a.cache = 4'h3; a.qos = {2'b0, m, 1'b1};
        e = '0; e.id = {m, id}; e.addr = addr; e.len = len; e.size = 3'd2; e.burst = 2'b01;
        e.cache = 4'h3; e.qos = {2'b0, m, 1'b1};
        if (m) exp_aw1.push_back(e); else exp_aw0.push_back(e);
        m_aw[m] = a;
        m_awvalid[m] = 1'b1;
        for (t = 0; t < 300; t++) begin
            @(negedge aclk);
            if (m_awready[m]) break;
        end
        if (t == 300) fail_now("aw_accept_timeout");
        @(posedge aclk); #1;
        m_awvalid[m] = 1'b0;
    endtask

    task automatic send_w(input logic m, input logic [3:0] id, input int nbeats);
        w_t  w;
        wx_t e;
        int  t;
        for (int i = 0; i < nbeats; i++) begin
            w.id = id; w.data = {8'hA0 + 8'(m), 4'h0, id, 16'(i)}; w.strb = 4'hF;
            w.last = (i == nbeats - 1);
            e.id = {m, id}; e.data = w.data; e.strb = 4'hF; e.last = w.last;
            if (m) exp_w1.push_back(e); else exp_w0.push_back(e);
            m_w[m] = w;
            m_wvalid[m] = 1'b1;
            for (t = 0; t < 300; t++) begin
                @(negedge aclk);
                if (m_wready[m]) break;
            end
            if (t == 300) fail_now("w_accept_timeout");
            @(posedge aclk); #1;
        end
        m_wvalid[m] = 1'b0;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        m_awvalid = '0; m_wvalid = '0;
        repeat (2) @(posedge aclk);
        #1 arst = 1'b0;
        exp_aw0.delete(); exp_aw1.delete(); exp_w0.delete(); exp_w1.delete();
        aw_order.delete();
    endtask

    typedef struct {
        logic       bvalid;
        logic [4:0] bid;
        logic [1:0] resp;
        logic [1:0] bready;
        logic [1:0] e_bvalid;
        logic [5:0] e_b;
        logic       e_bready;
    } bvec_t;

    bvec_t tbl[7];

    initial begin
        int t;
        int lec0;
        tbl[0] = '{1'b1, 5'h15, 2'd2, 2'b00, 2'b10, {4'h5, 2'd2}, 1'b0};
        tbl[1] = '{1'b1, 5'h15, 2'd2, 2'b01, 2'b10, {4'h5, 2'd2}, 1'b0};
        tbl[2] = '{1'b1, 5'h15, 2'd2, 2'b10, 2'b10, {4'h5, 2'd2}, 1'b1};
        tbl[3] = '{1'b1, 5'h03, 2'd0, 2'b01, 2'b01, {4'h3, 2'd0}, 1'b1};
        tbl[4] = '{1'b1, 5'h03, 2'd0, 2'b10, 2'b01, {4'h3, 2'd0}, 1'b0};
        tbl[5] = '{1'b0, 5'h1F, 2'd3, 2'b11, 2'b00, {4'hF, 2'd3}, 1'b1};
        tbl[6] = '{1'b1, 5'h0A, 2'd1, 2'b11, 2'b01, {4'hA, 2'd1}, 1'b1};

        // Reset with every input asserted: outputs must still be forced low.
        arst = 1'b1; m_aw = '0; m_w = '0; s_b = '0; done = 1'b0;
        m_awvalid = 2'b11; m_wvalid = 2'b11; m_bready = 2'b11;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_m_awready", 128'(m_awready), 128'(2'b00));
        chk("rst_m_bvalid", 128'(m_bvalid), 128'(2'b00));
        chk("rst_s_bready", 128'(s_bready), 128'(1'b0));
        chk("rst_busy_grant", 128'({busy, grant, len_err}), 128'(3'b000));
        @(posedge aclk); #1;
        arst = 1'b0; m_awvalid = '0; m_wvalid = '0; s_bvalid = 1'b0; m_bready = '0;
        @(negedge aclk);
        chk("post_rst_idle", 128'({busy, s_awvalid, s_wvalid}), 128'(3'b000));

        // Single master burst: AW latency and tag.
        @(posedge aclk); #1;
        begin
            aw_t  a;
            awx_t e;
            a = '0; a.id = 4'h3; a.addr = 32'h100; a.len = 4'd3;
            e = '0; e.id = 5'h03; e.addr = 32'h100; e.len = 4'd3;
            exp_aw0.push_back(e);
            m_aw[0] = a; m_awvalid[0] = 1'b1;
        end
        @(negedge aclk);
        chk("t1_m_awready", 128'(m_awready), 128'(2'b01));
        chk("t1_s_awvalid_early", 128'(s_awvalid), 128'(1'b0));
        @(posedge aclk); #1;
        m_awvalid[0] = 1'b0;
        @(negedge aclk);
        chk("t1_s_awvalid", 128'(s_awvalid), 128'(1'b1));
        chk("t1_s_aw_id", 128'(s_aw.id), 128'(5'h03));
        chk("t1_busy", 128'(busy), 128'(1'b1));
        @(posedge aclk); #1;
        send_w(1'b0, 4'h3, 4);
        @(negedge aclk);
        chk("t1_busy_drop", 128'(busy), 128'(1'b0));
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("t1_no_len_err", 128'(len_err_cnt), 128'(0));

        // Simultaneous requests after reset: master 0 first, master 1 right after.
        @(posedge aclk); #1;
        do_reset();
        fork
            begin send_aw(1'b0, 4'h1, 32'h1000, 4'd1); send_w(1'b0, 4'h1, 2); end
            begin send_aw(1'b1, 4'h2, 32'h2000, 4'd2); send_w(1'b1, 4'h2, 3); end
        join
        @(negedge aclk);
        chk("t2_order_n", 128'(aw_order.size()), 128'(2));
        if (aw_order.size() == 2) begin
            chk("t2_first", 128'(aw_order[0]), 128'(1'b0));
            chk("t2_second", 128'(aw_order[1]), 128'(1'b1));
        end
        chk("t2_m1_grant_cycle", 128'(acc1_cyc), 128'(wlast0_cyc + 1));

        // AW backpressure for 5 cycles then toggling W ready.
        @(posedge aclk); #1;
        s_awready = 1'b0; done = 1'b0;
        fork
            begin send_aw(1'b0, 4'h6, 32'h200, 4'd3); send_w(1'b0, 4'h6, 4); done = 1'b1; end
            begin
                awx_t snap;
                for (t = 0; t < 50; t++) begin
                    @(negedge aclk);
                    if (s_awvalid) break;
                end
                if (t == 50) fail_now("t3_awvalid_timeout");
                snap = s_aw;
                for (int i = 0; i < 5; i++) begin
                    chk("t3_awvalid_held", 128'(s_awvalid), 128'(1'b1));
                    chk("t3_aw_stable", 128'(s_aw), 128'(snap));
                    @(negedge aclk);
                end
                @(posedge aclk); #1;
                s_awready = 1'b1;
                for (int i = 0; i < 200 && !done; i++) begin
                    @(posedge aclk); #1;
                    s_wready = ~s_wready;
                    @(negedge aclk);
                    if (busy && !s_awvalid)
                        chk("t3_wready_mirror", 128'(m_wready), 128'({1'b0, s_wready}));
                end
            end
        join
        s_wready = 1'b1;
        chk("t3_w_drained", 128'(exp_w0.size()), 128'(0));

        // Early wlast: one length error, burst ends, stray beat stalls.
        @(posedge aclk); #1;
        lec0 = len_err_cnt;
        send_aw(1'b1, 4'h5, 32'h300, 4'd3);
        send_w(1'b1, 4'h5, 2);
        @(negedge aclk);
        chk("t4_len_err", 128'(len_err), 128'(1'b1));
        chk("t4_idle", 128'(busy), 128'(1'b0));
        @(posedge aclk); #1;
        m_wvalid[1] = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            chk("t4_stray_stalled", 128'({s_wvalid, m_wready}), 128'(3'b000));
        end
        @(posedge aclk); #1;
        m_wvalid[1] = 1'b0;
        chk("t4_len_err_once", 128'(len_err_cnt - lec0), 128'(1));

        // B routing table and backpressure, with a write burst in flight.
        fork
            begin send_aw(1'b0, 4'h9, 32'h500, 4'd3); send_w(1'b0, 4'h9, 4); end
            begin
                foreach (tbl[i]) begin
                    @(posedge aclk); #1;
                    s_bvalid = tbl[i].bvalid; s_b.id = tbl[i].bid; s_b.resp = tbl[i].resp;
                    m_bready = tbl[i].bready;
                    @(negedge aclk);
                    chk("b_vec_bvalid", 128'(m_bvalid), 128'(tbl[i].e_bvalid));
                    chk("b_vec_payload", 128'(m_b), 128'(tbl[i].e_b));
                    chk("b_vec_bready", 128'(s_bready), 128'(tbl[i].e_bready));
                end
                @(posedge aclk); #1;
                s_bvalid = 1'b1; s_b.id = 5'h15; s_b.resp = 2'd2; m_bready = 2'b01;
                repeat (3) begin
                    @(negedge aclk);
                    chk("b_hold_bvalid", 128'(m_bvalid), 128'(2'b10));
                    chk("b_hold_id", 128'(m_b.id), 128'(4'h5));
                    chk("b_hold_bready", 128'(s_bready), 128'(1'b0));
                    @(posedge aclk); #1;
                end
                m_bready = 2'b11;
                @(negedge aclk);
                chk("b_release_bready", 128'(s_bready), 128'(1'b1));
                @(posedge aclk); #1;
                s_bvalid = 1'b0; m_bready = '0;
            end
        join

        // Reset in the middle of a data burst.
        @(posedge aclk); #1;
        send_aw(1'b0, 4'h7, 32'h400, 4'd3);
        begin
            wx_t e;
            m_w[0].id = 4'h7; m_w[0].data = 32'hDEAD0000; m_w[0].strb = 4'hF; m_w[0].last = 1'b0;
            e.id = 5'h07; e.data = 32'hDEAD0000; e.strb = 4'hF; e.last = 1'b0;
            exp_w0.push_back(e);
            m_wvalid[0] = 1'b1;
        end
        for (t = 0; t < 50; t++) begin
            @(negedge aclk);
            if (m_wready[0]) break;
        end
        if (t == 50) fail_now("t6_beat0_timeout");
        @(posedge aclk); #1;
        m_w[0].data = 32'hDEAD0001;
        arst = 1'b1; m_awvalid = 2'b11; s_bvalid = 1'b1; s_b.id = 5'h15; m_bready = 2'b11;
        @(negedge aclk);
        chk("t6_rst_valids", 128'({s_awvalid, s_wvalid, m_bvalid}), 128'(4'b0000));
        chk("t6_rst_readys", 128'({m_awready, m_wready, s_bready}), 128'(5'b00000));
        chk("t6_rst_status", 128'({grant, busy, len_err}), 128'(3'b000));
        @(posedge aclk); #1;
        arst = 1'b0; m_wvalid = '0; s_bvalid = 1'b0; m_bready = '0;
        exp_aw0.delete(); exp_w0.delete();
        @(negedge aclk);
        chk("t6_idle_after", 128'(busy), 128'(1'b0));
        chk("t6_m0_priority", 128'(m_awready), 128'(2'b01));
        m_awvalid = '0;
        @(posedge aclk); #1;

        chk("end_queues_empty",
            128'(exp_aw0.size() + exp_aw1.size() + exp_w0.size() + exp_w1.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
